// File: rtl/inc_pulse_pkg.sv
// inc_pulse_gen shared types: debounce state, counter width,
// and the parameter legality check used at elaboration.
package inc_pulse_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } db_state_t;

  function automatic bit params_ok(
    input int db,
    input int ss
  );
    return (db >= 1) && (db <= 255) &&
           (ss >= 2) && (ss <= 3);
  endfunction

endpackage

// File: rtl/inc_pulse_gen_if.sv
// Request/strobe/level bundle between the request source
// and the increment pulse generator.
interface inc_pulse_gen_if;

  logic REQA;
  logic REQB;
  logic INCA;
  logic INCB;
  logic LVLA;
  logic LVLB;

  modport master (
    output REQA, REQB,
    input  INCA, INCB, LVLA, LVLB
  );

  modport slave (
    input  REQA, REQB,
    output INCA, INCB, LVLA, LVLB
  );

endinterface

// File: rtl/inc_pulse_chan.sv
// One request channel: synchroniser, debounce FSM with
// stability counter, and the registered increment strobe.
module inc_pulse_chan
  import inc_pulse_pkg::*;
#(
  parameter int DB_CYCLES   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic ck,
  input  logic rst,
  input  logic en,
  input  logic req,
  output logic inc,
  output logic lvl
);

  localparam logic [CNT_W-1:0] DB = CNT_W'(DB_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  db_state_t              state;
  db_state_t              state_nx;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nx;
  logic                   accept;
  logic                   inc_q;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], req};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // The strobe is rebuilt every edge, so it can
  // never last longer than one cycle.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state <= LOW;
      cnt   <= '0;
      inc_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      inc_q <= accept & en;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    unique case (state)
      LOW: begin
        if (s) begin
          state_nx = RISE_CHK;
          cnt_nx   = CNT_W'(1);
        end
      end
      RISE_CHK: begin
        if (!s) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end else if (cnt == DB) begin
          state_nx = HIGH;
          cnt_nx   = '0;
          accept   = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_nx = FALL_CHK;
          cnt_nx   = CNT_W'(1);
        end
      end
      FALL_CHK: begin
        if (s) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end else if (cnt == DB) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    inc = inc_q;
    lvl = (state == HIGH) ||
          (state == FALL_CHK);
  end

endmodule

// File: rtl/inc_pulse_gen.sv
// INCA/INCB strobe generator: two independent debounced
// rising-edge channels sharing clock, reset and enable.
module inc_pulse_gen
  import inc_pulse_pkg::*;
#(
  parameter int DB_CYCLES   = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic            ck,
  input logic            rst,
  input logic            en,
  inc_pulse_gen_if.slave bus
);

  if (!params_ok(DB_CYCLES, SYNC_STAGES)) begin : g_bad_param
    $error("inc_pulse_gen: DB_CYCLES/SYNC_STAGES out of range");
  end

  inc_pulse_chan #(
    .DB_CYCLES  (DB_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_chan_a (
    .ck (ck),
    .rst(rst),
    .en (en),
    .req(bus.REQA),
    .inc(bus.INCA),
    .lvl(bus.LVLA)
  );

  inc_pulse_chan #(
    .DB_CYCLES  (DB_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_chan_b (
    .ck (ck),
    .rst(rst),
    .en (en),
    .req(bus.REQB),
    .inc(bus.INCB),
    .lvl(bus.LVLB)
  );

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Scoreboard bench for inc_pulse_gen: run-length debounce
// model feeds per-channel pulse queues; monitor compares.
module tb_inc_pulse_gen;

  localparam int DB = 4;
  localparam int SS = 2;

  logic ck  = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b1;

  inc_pulse_gen_if bus();

  inc_pulse_gen #(
    .DB_CYCLES  (DB),
    .SYNC_STAGES(SS)
  ) dut (
    .ck (ck),
    .rst(rst),
    .en (en),
    .bus(bus)
  );

  always #5 ck = ~ck;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit lv  [2];
  int run [2];
  bit dl  [2][SS];
  int qa[$];
  int qb[$];
  int pcnt [2];
  int plast[2];

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0b exp=%0b cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Reference: the level flips once the delayed request has
  // disagreed with it for DB+1 consecutive edges.
  always @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        lv[c]  = 1'b0;
        run[c] = 0;
        for (int k = 0; k < SS; k++) dl[c][k] = 1'b0;
      end
      qa.delete();
      qb.delete();
    end else begin
      cyc++;
      for (int c = 0; c < 2; c++) begin
        bit r;
        bit s;
        r = (c == 0) ? bus.REQA : bus.REQB;
        s = dl[c][SS-1];
        for (int k = SS - 1; k > 0; k--) dl[c][k] = dl[c][k-1];
        dl[c][0] = r;
        if (s != lv[c]) begin
          run[c]++;
          if (run[c] == DB + 1) begin
            lv[c]  = s;
            run[c] = 0;
            if (s && en) begin
              if (c == 0) qa.push_back(cyc);
              else        qb.push_back(cyc);
            end
          end
        end else begin
          run[c] = 0;
        end
      end
    end
  end

  always @(negedge ck) begin
    for (int c = 0; c < 2; c++) begin
      logic i;
      logic l;
      bit   e;
      i = (c == 0) ? bus.INCA : bus.INCB;
      l = (c == 0) ? bus.LVLA : bus.LVLB;
      if (!rst) begin
        chk(c == 0 ? "rst_inca" : "rst_incb", i, 1'b0);
        chk(c == 0 ? "rst_lvla" : "rst_lvlb", l, 1'b0);
      end else begin
        e = 1'b0;
        if (c == 0 && qa.size() > 0 && qa[0] == cyc) begin
          e = 1'b1;
          void'(qa.pop_front());
        end
        if (c == 1 && qb.size() > 0 && qb[0] == cyc) begin
          e = 1'b1;
          void'(qb.pop_front());
        end
        chk(c == 0 ? "inca" : "incb", i, e);
        chk(c == 0 ? "lvla" : "lvlb", l, lv[c]);
        if (i === 1'b1) begin
          pcnt[c]++;
          plast[c] = cyc;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  initial begin
    int e0;
    int pa0;
    int pb0;
    pcnt[0] = 0;
    pcnt[1] = 0;
    bus.REQA = 1'b0;
    bus.REQB = 1'b0;

    tick(3);
    chk("t1_rst_inca", bus.INCA, 1'b0);
    chk("t1_rst_lvla", bus.LVLA, 1'b0);

    rst      = 1'b1;
    bus.REQA = 1'b1;
    e0       = cyc + 1;
    tick(10);
    chki("t1_pulses", pcnt[0], 1);
    chki("t1_edge", plast[0], e0 + DB + SS);
    chki("t1_b_quiet", pcnt[1], 0);
    chk("t1_lvla", bus.LVLA, 1'b1);
    bus.REQA = 1'b0;
    tick(12);

    pa0 = pcnt[0];
    bus.REQA = 1'b1;
    tick(3);
    bus.REQA = 1'b0;
    tick(10);
    chki("t2_glitch", pcnt[0] - pa0, 0);
    chk("t2_lvla", bus.LVLA, 1'b0);

    pb0 = pcnt[1];
    bus.REQB = 1'b1; tick(1);
    bus.REQB = 1'b0; tick(1);
    bus.REQB = 1'b1; tick(1);
    bus.REQB = 1'b0; tick(1);
    bus.REQB = 1'b1;
    e0 = cyc + 1;
    tick(10);
    chki("t3_edge", plast[1], e0 + DB + SS);
    tick(50);
    chki("t3_once", pcnt[1] - pb0, 1);
    bus.REQB = 1'b0;
    tick(12);

    pa0 = pcnt[0];
    pb0 = pcnt[1];
    for (int k = 0; k < 5; k++) begin
      bus.REQA = 1'b1;
      bus.REQB = 1'b1;
      tick(10);
      chki("t4_same_cyc", plast[0], plast[1]);
      bus.REQA = 1'b0;
      bus.REQB = 1'b0;
      tick(10);
    end
    chki("t4_a5", pcnt[0] - pa0, 5);
    chki("t4_b5", pcnt[1] - pb0, 5);

    pa0 = pcnt[0];
    en = 1'b0;
    bus.REQA = 1'b1;
    tick(10);
    en = 1'b1;
    tick(10);
    chki("t5_suppr", pcnt[0] - pa0, 0);
    bus.REQA = 1'b0;
    tick(10);
    bus.REQA = 1'b1;
    tick(10);
    chki("t5_after", pcnt[0] - pa0, 1);
    bus.REQA = 1'b0;
    tick(12);

    pa0 = pcnt[0];
    bus.REQA = 1'b1;
    tick(5);
    rst = 1'b0;
    #1;
    chk("t6_inca", bus.INCA, 1'b0);
    chk("t6_lvla", bus.LVLA, 1'b0);
    tick(2);
    chki("t6_none", pcnt[0] - pa0, 0);
    rst = 1'b1;
    e0  = cyc + 1;
    tick(10);
    chki("t6_edge", plast[0], e0 + DB + SS);
    chki("t6_once", pcnt[0] - pa0, 1);
    bus.REQA = 1'b0;
    tick(12);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) bus.REQA = ~bus.REQA;
      if ($urandom_range(0, 7) == 0) bus.REQB = ~bus.REQB;
      if ($urandom_range(0, 15) == 0) en = ~en;
      tick(1);
    end
    bus.REQA = 1'b0;
    bus.REQB = 1'b0;
    tick(20);
    chki("pend_a", qa.size(), 0);
    chki("pend_b", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
